mips_pipe_stage: RTL and testbench
==================================

# mips_pipe_stage

Parametrised pipeline stage register for the MIPS datapath, replacing fixed-width hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control-signal bundle and a data bundle between two stages using a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` registered. Supports hazard-unit stall (via `out_ready`) and flush with bubble insertion. One instance sits between each pair of adjacent pipeline stages.

## Interface
- `CTRL_W`, 18: width of control bundle.
- `DATA_W`, 64: width of data bundle (PC, operands, immediates, register addresses).
- `CTRL_NOP`, all zeros: control pattern driven as a bubble; must deassert rf_enable, load, branch and memory writes.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream stage presents an instruction.
- `in_ready`  out  1  stage can accept; registered; depends only on state.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `flush`  in  1  discard all held instructions; from branch/jump resolution.
- `out_valid`  out  1  downstream holds a valid instruction.
- `out_ready`  in  1  downstream accepts; 0 = stall from hazard unit.
- `out_ctrl`  out  CTRL_W  control to downstream; equals CTRL_NOP whenever out_valid=0.
- `out_data`  out  DATA_W  data to downstream.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready. All evaluated at posedge clk.
- Storage: main register (drives out_*) and skid register. Three states:
  - EMPTY (occ 0): out_valid=0, in_ready=1. Input transfer loads main, then ONE.
  - ONE (occ 1): out_valid=1, in_ready=1.
    - In + out together: main reloads, stays ONE.
    - Out only: EMPTY.
    - In only (stall): incoming goes to skid, then FULL.
  - FULL (occ 2): out_valid=1, in_ready=0. Output transfer moves skid into main, then ONE. in_valid is ignored in FULL.
- Ordering: strict FIFO. Skid content never overtakes main.
- Flush: next state is EMPTY regardless of state or handshakes. A same-cycle input transfer is dropped. A same-cycle output transfer still completes downstream, since out_* were valid that cycle. out_ctrl becomes CTRL_NOP the next cycle. out_data and skid data keep their old values and are don't-care.
- Bubble: out_ctrl is muxed registered-side so it equals CTRL_NOP whenever out_valid=0. No combinational path from in_* or flush to out_*.
- Reset: state EMPTY, out_valid=0, in_ready=1, out_ctrl=CTRL_NOP, out_data=0, occupancy=0, skid contents=0. Reset has priority over flush and all transfers.
- No assertions on protocol. in_valid may drop without handshake. in_ctrl and in_data are sampled only on an input transfer.

## Timing
- Latency: 1 cycle from an input transfer in EMPTY/ONE to the data appearing on out_*.
- Throughput: 1 instruction per cycle when out_ready=1 continuously.
- in_ready is a pure register output; a stall reaches upstream one cycle late, and the skid entry absorbs the in-flight instruction.
- out_ready to in_ready: FULL is entered only after a stall coincides with an input transfer. in_ready returns to 1 the cycle after the first output transfer in FULL.
- flush at edge N: out_valid=0 and occupancy=0 from N+1. in_ready=1 from N+1.
- No combinational path from any input to any output.

## Test plan
- Streaming: reset, then in_valid=1 with in_ctrl=0x00001..0x00005 on consecutive cycles, out_ready=1.
  - Required: out_ctrl shows 1..5 one cycle delayed, out_valid continuous, occupancy=1, in_ready=1 throughout.
- Stall into skid: send A=0x11, B=0x22, C=0x33 back-to-back; hold out_ready=0 from the cycle A appears.
  - Required: B captured in skid, occupancy=2, in_ready=0, C held upstream.
  - Release out_ready: order A, B, C with no loss or duplication.
- Flush while FULL: same cycle as an input offer.
  - Required: next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, in_ready=1; offered instruction never appears.
- Flush with out_ready=1 in ONE holding 0x2A:
  - Required: 0x2A counted as transferred that edge; following cycle bubble (CTRL_NOP).
- Reset mid-operation: assert reset in FULL with flush=1 and in_valid=1.
  - Required: next cycle out_data=0, out_ctrl=CTRL_NOP, occupancy=0, in_ready=1.
- Random: CTRL_W=7 and DATA_W=1 instances, random valid/ready/flush for 10k cycles against a reference queue.
  - Required: FIFO order preserved; out_ctrl==CTRL_NOP whenever out_valid=0.

Source files
------------

// File: rtl/mips_pipe_if.sv
// Handshake bus between two adjacent MIPS pipeline stages.
// valid : producer holds an instruction
// ready : consumer can take it this edge
// ctrl  : control-signal bundle (CTRL_W bits)
// data  : data bundle: PC, operands, immediates, register addresses (DATA_W bits)
interface mips_pipe_if #(
   parameter int CTRL_W = 18,
   parameter int DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input ready);
   modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/mips_pipe_stage.sv
// Parametrised inter-stage pipeline register with a 2-entry skid buffer.
// clk, reset : clock, synchronous active-high reset
// flush      : drop every held instruction (branch/jump resolution)
// in_bus     : upstream handshake (slave); in_bus.ready is a pure register
// out_bus    : downstream handshake (master); ctrl is CTRL_NOP when not valid
// occupancy  : number of held entries, 0..2
//
// state    | meaning
// ST_EMPTY | nothing held, bubble on out_*
// ST_ONE   | main register holds the oldest instruction
// ST_FULL  | main and skid both hold instructions, upstream is stalled
module mips_pipe_stage #(
   parameter int                CTRL_W   = 18,
   parameter int                DATA_W   = 64,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   mips_pipe_if.slave  in_bus,
   mips_pipe_if.master out_bus,
   output logic [1:0]  occupancy
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              valid_q;
   logic              ready_q;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic in_xfer;
   logic out_xfer;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;
   logic clear_ctrl;

   assign in_xfer  = in_bus.valid & ready_q;
   assign out_xfer = valid_q & out_bus.ready;

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_ctrl     = 1'b0;
      if (flush) begin
         // any output transfer this edge has already completed downstream
         state_nxt  = ST_EMPTY;
         clear_ctrl = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  load_main_in = 1'b1;
                  state_nxt    = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  load_main_in = 1'b1;
               end else if (out_xfer) begin
                  state_nxt  = ST_EMPTY;
                  clear_ctrl = 1'b1;
               end else if (in_xfer) begin
                  // stall arrived too late for upstream: park the in-flight one
                  load_skid = 1'b1;
                  state_nxt = ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  load_main_skid = 1'b1;
                  state_nxt      = ST_ONE;
               end
            end
            default: begin
               state_nxt  = ST_EMPTY;
               clear_ctrl = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_EMPTY;
         valid_q   <= 1'b0;
         ready_q   <= 1'b1;
         main_ctrl <= CTRL_NOP;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         state   <= state_nxt;
         valid_q <= (state_nxt != ST_EMPTY);
         ready_q <= (state_nxt != ST_FULL);

         // bubble is forced on the register side so out_ctrl has no comb path
         if (load_main_in) begin
            main_ctrl <= in_bus.ctrl;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
         end else if (clear_ctrl) begin
            main_ctrl <= CTRL_NOP;
         end

         // data is don't-care while empty, so it is left untouched on a bubble
         if (load_main_in) begin
            main_data <= in_bus.data;
         end else if (load_main_skid) begin
            main_data <= skid_data;
         end

         if (load_skid) begin
            skid_ctrl <= in_bus.ctrl;
            skid_data <= in_bus.data;
         end
      end
   end

   assign out_bus.valid = valid_q;
   assign out_bus.ctrl  = main_ctrl;
   assign out_bus.data  = main_data;
   assign in_bus.ready  = ready_q;
   assign occupancy     = state;

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Bench for mips_pipe_stage: a full-width (18/64) and a narrow (7/1) instance
// share one stimulus stream; both are checked every cycle against a queue model
// of a 2-deep FIFO stage, with literal expectations pinning the directed cases.
module tb_mips_pipe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        fl;
   logic        iv;
   logic        ordy;
   logic [17:0] ictl;
   logic [63:0] idat;

   logic [1:0] big_occ;
   logic [1:0] sml_occ;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_pipe_if #(.CTRL_W(18), .DATA_W(64)) big_in ();
   mips_pipe_if #(.CTRL_W(18), .DATA_W(64)) big_out ();
   mips_pipe_if #(.CTRL_W(7),  .DATA_W(1))  sml_in ();
   mips_pipe_if #(.CTRL_W(7),  .DATA_W(1))  sml_out ();

   assign big_in.valid  = iv;
   assign big_in.ctrl   = ictl;
   assign big_in.data   = idat;
   assign big_out.ready = ordy;
   assign sml_in.valid  = iv;
   assign sml_in.ctrl   = ictl[6:0];
   assign sml_in.data   = idat[0:0];
   assign sml_out.ready = ordy;

   mips_pipe_stage #(.CTRL_W(18), .DATA_W(64), .CTRL_NOP(18'h0)) dut_big (
      .clk       (clk),
      .reset     (rst),
      .flush     (fl),
      .in_bus    (big_in),
      .out_bus   (big_out),
      .occupancy (big_occ)
   );

   mips_pipe_stage #(.CTRL_W(7), .DATA_W(1), .CTRL_NOP(7'h0)) dut_sml (
      .clk       (clk),
      .reset     (rst),
      .flush     (fl),
      .in_bus    (sml_in),
      .out_bus   (sml_out),
      .occupancy (sml_occ)
   );

   // model: the instructions currently held, oldest first (capacity 2)
   typedef struct packed {
      logic [17:0] c;
      logic [63:0] d;
   } ent_t;
   ent_t q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      ent_t e;
      logic do_out;
      logic do_in;
      if (rst || fl) begin
         q.delete();
      end else begin
         do_out = (q.size() > 0) && ordy;
         do_in  = iv && (q.size() < 2);
         if (do_out) void'(q.pop_front());
         if (do_in) begin
            e.c = ictl;
            e.d = idat;
            q.push_back(e);
         end
      end
   endtask

   task automatic compare_all();
      logic        ev;
      logic [17:0] ec;
      logic [63:0] ed;
      ev = (q.size() > 0);
      ec = ev ? q[0].c : 18'h0;
      ed = ev ? q[0].d : 64'h0;
      chk("big out_valid", 64'(big_out.valid), 64'(ev));
      chk("big in_ready", 64'(big_in.ready), 64'(q.size() < 2));
      chk("big occupancy", 64'(big_occ), 64'(q.size()));
      chk("big out_ctrl", 64'(big_out.ctrl), 64'(ec));
      if (ev) chk("big out_data", big_out.data, ed);
      chk("sml out_valid", 64'(sml_out.valid), 64'(ev));
      chk("sml in_ready", 64'(sml_in.ready), 64'(q.size() < 2));
      chk("sml occupancy", 64'(sml_occ), 64'(q.size()));
      chk("sml out_ctrl", 64'(sml_out.ctrl), 64'(ec[6:0]));
      if (ev) chk("sml out_data", 64'(sml_out.data), 64'(ed[0]));
   endtask

   // drive one cycle, advance the model at the edge, compare mid-cycle
   task automatic cyc(input logic r, input logic f, input logic v,
                      input logic [17:0] c, input logic [63:0] d, input logic o);
      rst  = r;
      fl   = f;
      iv   = v;
      ictl = c;
      idat = d;
      ordy = o;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst = 1'b1; fl = 1'b0; iv = 1'b0; ordy = 1'b0; ictl = '0; idat = '0;

      // reset
      cyc(1, 0, 0, 18'h0, 64'h0, 0);
      chk("lit reset occ", 64'(big_occ), 64'd0);
      chk("lit reset in_ready", 64'(big_in.ready), 64'd1);
      chk("lit reset out_valid", 64'(big_out.valid), 64'd0);
      chk("lit reset out_ctrl", 64'(big_out.ctrl), 64'd0);
      chk("lit reset out_data", big_out.data, 64'd0);

      // streaming 1..5, each visible one cycle later
      for (int k = 1; k <= 5; k++) begin
         cyc(0, 0, 1, 18'(k), 64'(k * 16), 1);
         chk("lit stream ctrl", 64'(big_out.ctrl), 64'(k));
         chk("lit stream data", big_out.data, 64'(k * 16));
         chk("lit stream occ", 64'(big_occ), 64'd1);
         chk("lit stream in_ready", 64'(big_in.ready), 64'd1);
      end
      cyc(0, 0, 0, 18'h0, 64'h0, 1);
      chk("lit stream drain", 64'(big_out.valid), 64'd0);

      // stall into skid: A, B, C back to back, stall from the cycle A appears
      cyc(0, 0, 1, 18'h11, 64'hA, 0);
      cyc(0, 0, 1, 18'h22, 64'hB, 0);
      chk("lit stall occ", 64'(big_occ), 64'd2);
      chk("lit stall in_ready", 64'(big_in.ready), 64'd0);
      cyc(0, 0, 1, 18'h33, 64'hC, 0);
      chk("lit stall hold ctrl", 64'(big_out.ctrl), 64'h11);
      cyc(0, 0, 1, 18'h33, 64'hC, 1);
      chk("lit release B", 64'(big_out.ctrl), 64'h22);
      chk("lit release in_ready", 64'(big_in.ready), 64'd1);
      cyc(0, 0, 1, 18'h33, 64'hC, 1);
      chk("lit release C", 64'(big_out.ctrl), 64'h33);
      chk("lit release C data", big_out.data, 64'hC);
      cyc(0, 0, 0, 18'h0, 64'h0, 1);
      chk("lit release empty", 64'(big_occ), 64'd0);

      // flush while FULL, same cycle as an input offer
      cyc(0, 0, 1, 18'h44, 64'h4, 0);
      cyc(0, 0, 1, 18'h55, 64'h5, 0);
      cyc(0, 1, 1, 18'h66, 64'h6, 0);
      chk("lit flush full valid", 64'(big_out.valid), 64'd0);
      chk("lit flush full ctrl", 64'(big_out.ctrl), 64'd0);
      chk("lit flush full occ", 64'(big_occ), 64'd0);
      chk("lit flush full in_ready", 64'(big_in.ready), 64'd1);
      cyc(0, 0, 0, 18'h0, 64'h0, 1);
      chk("lit flush full stays empty", 64'(big_out.valid), 64'd0);

      // flush in ONE holding 0x2A with out_ready=1, input offered and dropped
      cyc(0, 0, 1, 18'h2A, 64'h2A, 0);
      chk("lit one holds 2A", 64'(big_out.ctrl), 64'h2A);
      cyc(0, 1, 1, 18'h77, 64'h77, 1);
      chk("lit flush one bubble", 64'(big_out.ctrl), 64'd0);
      chk("lit flush one occ", 64'(big_occ), 64'd0);
      cyc(0, 0, 0, 18'h0, 64'h0, 1);
      chk("lit flush one dropped", 64'(big_out.valid), 64'd0);

      // reset mid-operation in FULL with flush and in_valid
      cyc(0, 0, 1, 18'h12, 64'h1234, 0);
      cyc(0, 0, 1, 18'h34, 64'h3456, 0);
      chk("lit pre-reset occ", 64'(big_occ), 64'd2);
      cyc(1, 1, 1, 18'h56, 64'h5678, 1);
      chk("lit midreset data", big_out.data, 64'd0);
      chk("lit midreset ctrl", 64'(big_out.ctrl), 64'd0);
      chk("lit midreset occ", 64'(big_occ), 64'd0);
      chk("lit midreset in_ready", 64'(big_in.ready), 64'd1);

      // random traffic against the queue model
      for (int n = 0; n < 10000; n++) begin
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 7),
             18'($urandom),
             {$urandom, $urandom},
             ($urandom_range(0, 9) < 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
